mil_spi_ring_buffer: RTL and testbench

- Transactional 16-bit word FIFO (ring buffer) between a MIL link and the SPI link; one instance per direction per channel (MIL0->SPI, SPI->MIL0, MIL1->SPI, SPI->MIL1).
- Producer pushes words in; consumer pops words out inside an open/commit/rollback read transaction. An aborted SPI transfer can be replayed without losing data.
- Exports memUsed and memFree for status-word generation and SPI frame sizing.

---
 rtl/mil_spi_ring_buffer.sv | 138 +++++++++++++
 tb/tb_mil_spi_ring_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mil_spi_ring_buffer.sv
`default_nettype none
// ============================================================================
// mil_spi_ring_buffer : transactional word FIFO with open/commit/rollback reads
// Optional overflow counter: define MILSPI_RB_OVF_CNT_EN
// Revision: 1.0
// ============================================================================
module mil_spi_ring_buffer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pushRequest,
  input  logic [DATA_W-1:0] pushData,
  output logic              pushDone,
  input  logic              popRequest,
  output logic [DATA_W-1:0] popData,
  output logic              popDone,
  input  logic              open,
  input  logic              commit,
  input  logic              rollback,
  output logic [ADDR_W:0]   memUsed,
  output logic [ADDR_W:0]   memFree,
  output logic [7:0]        ovfCount
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_commit_q, rd_commit_d;
  logic [ADDR_W:0]   rd_work_q, rd_work_d;
  logic [ADDR_W:0]   mem_used_q, mem_used_d;
  logic [ADDR_W:0]   mem_free_q, mem_free_d;
  logic              push_done_q, push_done_d;
  logic              pop_done_q, pop_done_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              full, avail, push_acc, pop_acc;
  logic [ADDR_W:0]   rd_work_inc;

  always_comb begin
    // Fullness is measured against the committed pointer so unconfirmed
    // reads can always be replayed.
    full        = (wr_ptr_q - rd_commit_q) == C_DEPTH;
    avail       = rd_work_q != wr_ptr_q;
    push_acc    = pushRequest && !full;
    pop_acc     = popRequest && avail;
    rd_work_inc = pop_acc ? rd_work_q + C_ONE : rd_work_q;
    wr_ptr_d    = push_acc ? wr_ptr_q + C_ONE : wr_ptr_q;
    rd_work_d   = rd_work_inc;
    rd_commit_d = rd_commit_q;
    state_d     = state_q;
    case (state_q)
      ST_IDLE: begin
        // In IDLE rd_work always equals rd_commit, so pops commit immediately.
        rd_commit_d = rd_work_inc;
        if (open) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (rollback) begin
          rd_work_d = rd_commit_q;
          state_d   = ST_IDLE;
        end else if (commit) begin
          rd_commit_d = rd_work_inc;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    push_done_d = push_acc;
    pop_done_d  = pop_acc;
    pop_data_d  = pop_acc ? mem_q[rd_work_q[ADDR_W-1:0]] : pop_data_q;
    mem_used_d  = wr_ptr_d - rd_commit_d;
    mem_free_d  = C_DEPTH - mem_used_d;
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_commit_q <= '0;
      rd_work_q   <= '0;
      mem_used_q  <= '0;
      mem_free_q  <= C_DEPTH;
      push_done_q <= 1'b0;
      pop_done_q  <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_commit_q <= rd_commit_d;
      rd_work_q   <= rd_work_d;
      mem_used_q  <= mem_used_d;
      mem_free_q  <= mem_free_d;
      push_done_q <= push_done_d;
      pop_done_q  <= pop_done_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign pushDone = push_done_q;
  assign popDone  = pop_done_q;
  assign popData  = pop_data_q;
  assign memUsed  = mem_used_q;
  assign memFree  = mem_free_q;

`ifdef MILSPI_RB_OVF_CNT_EN
  logic [7:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (pushRequest && full && (ovf_count_q != 8'hFF)) ovf_count_d = ovf_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_count_q <= 8'd0;
    else     ovf_count_q <= ovf_count_d;
  end

  assign ovfCount = ovf_count_q;
`else
  assign ovfCount = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mil_spi_ring_buffer.sv
`default_nettype none
// ============================================================================
// tb_mil_spi_ring_buffer : scenario bench with a queue model and pop scoreboard
// Revision: 1.0
// ============================================================================
module tb_mil_spi_ring_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pushRequest = 1'b0;
  logic [15:0] pushData = '0;
  logic        pushDone;
  logic        popRequest = 1'b0;
  logic [15:0] popData;
  logic        popDone;
  logic        open = 1'b0;
  logic        commit = 1'b0;
  logic        rollback = 1'b0;
  logic [4:0]  memUsed;
  logic [4:0]  memFree;
  logic [7:0]  ovfCount;

  int n_checks = 0;
  int n_pass   = 0;

  // Buffer model: words from the committed read point to the write point.
  logic [15:0] mdl[$];
  logic [15:0] exp_q[$];
  int          work = 0;
  bit          open_st = 1'b0;
  logic [15:0] exp_w;

  mil_spi_ring_buffer #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .pushRequest(pushRequest), .pushData(pushData), .pushDone(pushDone),
    .popRequest(popRequest), .popData(popData), .popDone(popDone),
    .open(open), .commit(commit), .rollback(rollback),
    .memUsed(memUsed), .memFree(memFree), .ovfCount(ovfCount)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    pushRequest = 1'b0; pushData = '0; popRequest = 1'b0;
    open = 1'b0; commit = 1'b0; rollback = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    mdl.delete(); exp_q.delete(); work = 0; open_st = 1'b0;
  endtask

  // One clock of stimulus; expected pop data goes to the scoreboard.
  task automatic step(input bit push, input logic [15:0] d, input bit pop,
                      input bit op, input bit cm, input bit rb);
    bit full_m, pa, po;
    @(negedge clk);
    pushRequest = push; pushData = d; popRequest = pop;
    open = op; commit = cm; rollback = rb;
    full_m = (mdl.size() == 16);
    pa = push && !full_m;
    po = pop && (work < mdl.size());
    if (po) exp_q.push_back(mdl[work]);
    if (!open_st) begin
      if (po) void'(mdl.pop_front());
      if (op) open_st = 1'b1;
    end else begin
      if (po) work++;
      if (rb) begin
        work = 0; open_st = 1'b0;
      end else if (cm) begin
        repeat (work) void'(mdl.pop_front());
        work = 0; open_st = 1'b0;
      end
    end
    if (pa) mdl.push_back(d);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pushDone !== 1'b0) $display("FAIL reset_pushDone: got %b want 0", pushDone); else n_pass++;
    n_checks++; if (popDone !== 1'b0) $display("FAIL reset_popDone: got %b want 0", popDone); else n_pass++;
    n_checks++; if (popData !== 16'h0) $display("FAIL reset_popData: got %h want 0000", popData); else n_pass++;
    n_checks++; if (memUsed !== 5'd0) $display("FAIL reset_memUsed: got %0d want 0", memUsed); else n_pass++;
    n_checks++; if (memFree !== 5'd16) $display("FAIL reset_memFree: got %0d want 16", memFree); else n_pass++;
    n_checks++; if (ovfCount !== 8'd0) $display("FAIL reset_ovfCount: got %0d want 0", ovfCount); else n_pass++;
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(16'h1111 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (pushDone !== 1'b1) $display("FAIL pp_pushDone[%0d]: got %b want 1", i, pushDone); else n_pass++;
    end
    idle();
    n_checks++; if (memUsed !== 5'd6) $display("FAIL pp_memUsed6: got %0d want 6", memUsed); else n_pass++;
    n_checks++; if (memFree !== 5'd10) $display("FAIL pp_memFree10: got %0d want 10", memFree); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      n_checks++;
      if (popDone !== 1'b1 || popData !== exp_w || popData !== 16'(16'h1111 + i))
        $display("FAIL pp_pop[%0d]: popDone=%b popData=%h want 1/%h", i, popDone, popData, exp_w);
      else n_pass++;
    end
    idle();
    n_checks++; if (memUsed !== 5'd0) $display("FAIL pp_memUsed0: got %0d want 0", memUsed); else n_pass++;
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (popDone !== 1'b0 || popData !== 16'h1116)
      $display("FAIL pp_pop_empty: popDone=%b popData=%h want 0/1116", popDone, popData);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (pushDone !== 1'b1) $display("FAIL full_fill[%0d]: got %b want 1", i, pushDone); else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (pushDone !== 1'b0) $display("FAIL full_reject[%0d]: got %b want 0", k, pushDone); else n_pass++;
    end
    n_checks++; if (memUsed !== 5'd16) $display("FAIL full_memUsed16: got %0d want 16", memUsed); else n_pass++;
    n_checks++; if (memFree !== 5'd0) $display("FAIL full_memFree0: got %0d want 0", memFree); else n_pass++;
`ifdef MILSPI_RB_OVF_CNT_EN
    n_checks++; if (ovfCount !== 8'd3) $display("FAIL full_ovfCount: got %0d want 3", ovfCount); else n_pass++;
`else
    n_checks++; if (ovfCount !== 8'd0) $display("FAIL full_ovfCount: got %0d want 0", ovfCount); else n_pass++;
`endif
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    n_checks++;
    if (popDone !== 1'b1 || popData !== 16'h2000 || pushDone !== 1'b0)
      $display("FAIL full_pop_first: popDone=%b popData=%h pushDone=%b want 1/2000/0", popDone, popData, pushDone);
    else n_pass++;
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pushDone !== 1'b1) $display("FAIL full_dead_accept: got %b want 1", pushDone); else n_pass++;
    idle();
    n_checks++; if (memUsed !== 5'd16) $display("FAIL full_memUsed_refill: got %0d want 16", memUsed); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      n_checks++;
      if (popDone !== 1'b1 || popData !== exp_w)
        $display("FAIL full_drain[%0d]: popDone=%b popData=%h want 1/%h", i, popDone, popData, exp_w);
      else n_pass++;
    end
    n_checks++; if (popData !== 16'hDEAD) $display("FAIL full_last_dead: got %h want dead", popData); else n_pass++;
  endtask

  task automatic test_rollback_replay();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      n_checks++;
      if (popDone !== 1'b1 || popData !== exp_w)
        $display("FAIL rb_pop[%0d]: popDone=%b popData=%h want 1/%h", i, popDone, popData, exp_w);
      else n_pass++;
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    n_checks++; if (memUsed !== 5'd8) $display("FAIL rb_memUsed8: got %0d want 8", memUsed); else n_pass++;
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      n_checks++;
      if (popDone !== 1'b1 || popData !== exp_w || popData !== 16'(16'h3000 + i))
        $display("FAIL rb_replay[%0d]: popDone=%b popData=%h want 1/%h", i, popDone, popData, exp_w);
      else n_pass++;
    end
    n_checks++; if (memUsed !== 5'd8) $display("FAIL rb_memUsed_open: got %0d want 8", memUsed); else n_pass++;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    n_checks++; if (memUsed !== 5'd0) $display("FAIL rb_memUsed_commit: got %0d want 0", memUsed); else n_pass++;
  endtask

  task automatic test_full_uncommitted();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      n_checks++;
      if (popDone !== 1'b1 || popData !== exp_w)
        $display("FAIL fu_pop[%0d]: popDone=%b popData=%h want 1/%h", i, popDone, popData, exp_w);
      else n_pass++;
    end
    step(1'b1, 16'h4AAA, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pushDone !== 1'b0) $display("FAIL fu_push_reject: got %b want 0", pushDone); else n_pass++;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    n_checks++; if (memUsed !== 5'd12) $display("FAIL fu_memUsed12: got %0d want 12", memUsed); else n_pass++;
    step(1'b1, 16'h4AAA, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pushDone !== 1'b1) $display("FAIL fu_push_accept: got %b want 1", pushDone); else n_pass++;
    idle();
    n_checks++; if (memUsed !== 5'd13) $display("FAIL fu_memUsed13: got %0d want 13", memUsed); else n_pass++;
  endtask

  task automatic test_commit_rollback_same();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    n_checks++; if (memUsed !== 5'd6) $display("FAIL cr_rollback_wins: got %0d want 6", memUsed); else n_pass++;
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      n_checks++;
      if (popDone !== 1'b1 || popData !== exp_w)
        $display("FAIL cr_pop[%0d]: popDone=%b popData=%h want 1/%h", i, popDone, popData, exp_w);
      else n_pass++;
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    n_checks++;
    if (popDone !== 1'b1 || popData !== 16'h5002)
      $display("FAIL cr_pop_commit: popDone=%b popData=%h want 1/5002", popDone, popData);
    else n_pass++;
    idle();
    n_checks++; if (memUsed !== 5'd3) $display("FAIL cr_commit_count: got %0d want 3", memUsed); else n_pass++;
  endtask

  task automatic test_wrap();
    int  pushed, popped, max_used;
    bit  dp, dq;
    do_reset();
    pushed = 0; popped = 0; max_used = 0;
    while (popped < 40) begin
      for (int phase = 0; phase < 3; phase++) begin
        for (int k = 0; k < 7; k++) begin
          dp = (phase < 2) && (pushed < 40);
          dq = (phase > 0) && (popped < pushed);
          step(dp, 16'(16'h6000 + pushed), dq, 1'b0, 1'b0, 1'b0);
          if (dp) pushed++;
          if (dq) begin
            popped++;
            exp_w = 16'hxxxx; if (exp_q.size() > 0) exp_w = exp_q.pop_front();
            n_checks++;
            if (popDone !== 1'b1 || popData !== exp_w)
              $display("FAIL wrap_pop[%0d]: popDone=%b popData=%h want 1/%h", popped, popDone, popData, exp_w);
            else n_pass++;
          end
          if (int'(memUsed) > max_used) max_used = int'(memUsed);
        end
      end
    end
    n_checks++; if (max_used > 16) $display("FAIL wrap_max_used: got %0d want <=16", max_used); else n_pass++;
    idle();
    n_checks++; if (memUsed !== 5'd0) $display("FAIL wrap_memUsed0: got %0d want 0", memUsed); else n_pass++;
  endtask

  task automatic test_reset_open();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h7000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    rst = 1'b1; popRequest = 1'b1; pushRequest = 1'b1; pushData = 16'h7777;
    @(posedge clk);
    #1;
    n_checks++; if (memUsed !== 5'd0) $display("FAIL ro_memUsed: got %0d want 0", memUsed); else n_pass++;
    n_checks++; if (memFree !== 5'd16) $display("FAIL ro_memFree: got %0d want 16", memFree); else n_pass++;
    n_checks++; if (popDone !== 1'b0 || pushDone !== 1'b0)
      $display("FAIL ro_pulses: popDone=%b pushDone=%b want 0/0", popDone, pushDone); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    mdl.delete(); exp_q.delete(); work = 0; open_st = 1'b0;
    idle();
    n_checks++; if (popDone !== 1'b0 || pushDone !== 1'b0)
      $display("FAIL ro_after_pulses: popDone=%b pushDone=%b want 0/0", popDone, pushDone); else n_pass++;
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (popDone !== 1'b0) $display("FAIL ro_empty_pop: got %b want 0", popDone); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_rollback_replay();
    test_full_uncommitted();
    test_commit_rollback_same();
    test_wrap();
    test_reset_open();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
